// File: rtl/video_pkg.sv
// video_pkg: shared timing constants, fetch phases and small helpers for the
// ZX Spectrum 48K-style display generator.
//   - Frame geometry: 448 pixel clocks per line, 312 lines per frame.
//   - Active area: lines 0..191; fetch window hCount 0..255; display window
//     hCount 8..263 (the fetch/serialise pipeline adds 8 clocks of latency).
//   - Sync, interrupt and blanking intervals (all limits inclusive).
package video_pkg;

  typedef logic [8:0] cnt_t;

  localparam cnt_t H_TOTAL       = 9'd448;
  localparam cnt_t V_TOTAL       = 9'd312;

  localparam cnt_t ACT_V_END     = 9'd192;  // first line after the active area
  localparam cnt_t FETCH_H_END   = 9'd256;  // first clock after the fetch window
  localparam cnt_t DISP_H_START  = 9'd8;
  localparam cnt_t DISP_H_END    = 9'd263;

  localparam cnt_t HS_START      = 9'd344;
  localparam cnt_t HS_END        = 9'd375;
  localparam cnt_t VS_START      = 9'd248;
  localparam cnt_t VS_END        = 9'd251;
  localparam cnt_t IRQ_LINE      = 9'd248;
  localparam cnt_t IRQ_LEN       = 9'd64;

  localparam cnt_t BLANK_H_START = 9'd320;
  localparam cnt_t BLANK_H_END   = 9'd415;
  localparam cnt_t BLANK_V_START = 9'd240;
  localparam cnt_t BLANK_V_END   = 9'd255;

  localparam logic [12:0] ATTR_BASE = 13'h1800;

  // Position inside an 8-pixel character cell (hCount[2:0]).
  typedef enum logic [2:0] {
    PH_BMP_ADDR = 3'd0,  // bitmap address on vmmAddr
    PH_ATR_ADDR = 3'd1,  // attribute address out, bitmap byte arrives
    PH_ATR_DATA = 3'd2,  // attribute byte arrives
    PH_LOAD     = 3'd7   // hand the cell over to the serialiser
  } phase_e;

  function automatic logic in_range(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/video_counters.sv
// video_counters: raster position and frame counter.
//   clock      in   pixel clock
//   reset      in   synchronous, active-high; clears all counters
//   flash      out  frame-counter bit selected by FLASH_BIT (flash phase)
//   hCount     out  0..H_TOTAL-1, increments every clock
//   vCount     out  0..V_TOTAL-1, increments when hCount wraps
//   hWrap      out  hCount is on its last value
//   vWrap      out  vCount is on its last value
// The 5-bit frame counter steps when both counters wrap together.
module video_counters
  import video_pkg::*;
#(
  parameter int FLASH_BIT = 4
) (
  input  logic clock,
  input  logic reset,
  output logic flash,
  output cnt_t hCount,
  output cnt_t vCount,
  output logic hWrap,
  output logic vWrap
);

  logic [4:0] frameCount;

  assign hWrap = (hCount == H_TOTAL - 9'd1);
  assign vWrap = (vCount == V_TOTAL - 9'd1);
  assign flash = frameCount[FLASH_BIT];

  always_ff @(posedge clock) begin
    if (reset) begin
      hCount     <= '0;
      vCount     <= '0;
      frameCount <= '0;
    end else begin
      hCount <= hWrap ? '0 : hCount + 9'd1;
      if (hWrap) begin
        vCount <= vWrap ? '0 : vCount + 9'd1;
        if (vWrap) frameCount <= frameCount + 5'd1;
      end
    end
  end

endmodule

// File: rtl/video.sv
// video: ZX Spectrum 48K-style display generator on the RAM video port.
//   clock    in   pixel clock (7 MHz), also clocks the RAM video port
//   reset    in   synchronous, active-high
//   border   in   border colour {G,R,B}
//   vmmAddr  out  RAM video address
//   vmmData  in   RAM video data, valid one clock after vmmAddr
//   hsync    out  horizontal sync, active-high
//   vsync    out  vertical sync, active-high
//   irq      out  frame interrupt, active-high
//   r,g,b,i  out  colour and bright
//   blank    out  blanking interval (only with VIDEO_BLANK_EN defined)
// Optional feature macro: VIDEO_BLANK_EN adds the blank port and forces
// r/g/b/i low during blanking. Without it, border colour is driven there.
//
// Every output register is loaded from the raster position the counters will
// hold after the edge (hNext/vNext), so an output seen while the counters read
// (h,v) belongs to (h,v). Pixel x of a line appears at hCount x+8.
module video
  import video_pkg::*;
#(
  parameter int FLASH_BIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  border,
  output logic [12:0] vmmAddr,
  input  logic [7:0]  vmmData,
  output logic        hsync,
  output logic        vsync,
  output logic        irq,
  output logic        r,
  output logic        g,
  output logic        b,
  output logic        i
`ifdef VIDEO_BLANK_EN
  ,
  output logic        blank
`endif
);

  function automatic logic [2:0] cell_colour(input logic pix, input logic [2:0] ink,
                                             input logic [2:0] paper, input logic swap);
    return (pix ^ swap) ? ink : paper;
  endfunction

  cnt_t hCount, vCount, hNext, vNext;
  logic hWrap, vWrap, flash;

  video_counters #(.FLASH_BIT(FLASH_BIT)) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .flash  (flash),
    .hCount (hCount),
    .vCount (vCount),
    .hWrap  (hWrap),
    .vWrap  (vWrap)
  );

  always_comb begin
    hNext = hWrap ? '0 : hCount + 9'd1;
    vNext = vCount;
    if (hWrap) vNext = vWrap ? '0 : vCount + 9'd1;
  end

  // ---- stage p0: address generation and fetch latches ----
  logic        fetchCur, fetchNext;
  logic [7:0]  yNext;
  logic [4:0]  cNext;
  logic [12:0] addrNext;
  logic [7:0]  bmp_p0, atr_p0;

  assign fetchCur  = (vCount < ACT_V_END) && (hCount < FETCH_H_END);
  assign fetchNext = (vNext < ACT_V_END) && (hNext < FETCH_H_END);
  assign yNext     = vNext[7:0];
  assign cNext     = hNext[7:3];

  always_comb begin
    addrNext = '0;
    if (fetchNext) begin
      case (hNext[2:0])
        PH_BMP_ADDR: addrNext = {yNext[7:6], yNext[2:0], yNext[5:3], cNext};
        PH_ATR_ADDR: addrNext = ATTR_BASE | {3'b000, yNext[7:3], cNext};
        default:     addrNext = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (fetchCur && (hCount[2:0] == PH_ATR_ADDR)) bmp_p0 <= vmmData;
    if (fetchCur && (hCount[2:0] == PH_ATR_DATA)) atr_p0 <= vmmData;
  end

  // ---- stage p1: serialiser, colour and output registers ----
  // Bit 7 of the cell lives in the output register; shift_p1 holds the
  // pixels still to be shown.
  logic       load, vld_p1, pix;
  logic [6:0] shift_p1;
  logic [7:0] shiftNext, attr_p1, attrNext;
  logic [3:0] grbiNext;
  logic       blankNext;

  assign load      = fetchCur && (hCount[2:0] == PH_LOAD);
  assign shiftNext = load ? bmp_p0 : {shift_p1, 1'b0};
  assign attrNext  = load ? atr_p0 : attr_p1;
  assign pix       = shiftNext[7];
  assign vld_p1    = (vNext < ACT_V_END) && in_range(hNext, DISP_H_START, DISP_H_END);
  assign blankNext = in_range(hNext, BLANK_H_START, BLANK_H_END) ||
                     in_range(vNext, BLANK_V_START, BLANK_V_END);

  always_comb begin
    grbiNext = {border, 1'b0};
    if (vld_p1)
      grbiNext = {cell_colour(pix, attrNext[2:0], attrNext[5:3], attrNext[7] & flash),
                  attrNext[6]};
`ifdef VIDEO_BLANK_EN
    if (blankNext) grbiNext = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vmmAddr      <= '0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      irq          <= 1'b0;
      {g, r, b, i} <= '0;
      shift_p1     <= '0;
      attr_p1      <= '0;
    end else begin
      vmmAddr      <= addrNext;
      hsync        <= in_range(hNext, HS_START, HS_END);
      vsync        <= in_range(vNext, VS_START, VS_END);
      irq          <= (vNext == IRQ_LINE) && (hNext < IRQ_LEN);
      {g, r, b, i} <= grbiNext;
      shift_p1     <= shiftNext[6:0];
      attr_p1      <= attrNext;
    end
  end

`ifdef VIDEO_BLANK_EN
  always_ff @(posedge clock) begin
    if (reset) blank <= 1'b0;
    else       blank <= blankNext;
  end
`else
  logic unusedBlank;
  assign unusedBlank = blankNext;
`endif

endmodule

// File: tb/tb_video.sv
// tb_video: directed bench for the video display generator.
// The bench keeps its own raster model (hc, vc, fc); outputs are sampled on
// the falling edge. Long stretches of the frame are skipped by overriding the
// line and frame counters for one clock while they are not wrapping.
module tb_video;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  border;
  logic [12:0] vmmAddr;
  logic [7:0]  vmmData;
  logic        hsync, vsync, irq, r, g, b, i;
`ifdef VIDEO_BLANK_EN
  logic        blank;
`endif
  logic [3:0]  obs;

  logic [7:0]  mem [0:8191];

  int nchk = 0;
  int nbad = 0;
  int hc, vc, fc;
  int hs, vs_cnt, irq_cnt, irq_h, irq_v;

  always #5 clock = ~clock;

  video dut (
    .clock   (clock),
    .reset   (reset),
    .border  (border),
    .vmmAddr (vmmAddr),
    .vmmData (vmmData),
    .hsync   (hsync),
    .vsync   (vsync),
    .irq     (irq),
    .r       (r),
    .g       (g),
    .b       (b),
    .i       (i)
`ifdef VIDEO_BLANK_EN
    ,
    .blank   (blank)
`endif
  );

  assign obs = {r, g, b, i};

  // Registered-read RAM on the video port.
  always @(posedge clock) vmmData <= mem[vmmAddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s at h=%0d v=%0d f=%0d: got %0h expected %0h", tag, hc, vc, fc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (hc == 447) begin
      hc = 0;
      if (vc == 311) begin
        vc = 0;
        fc = (fc + 1) % 32;
      end else vc++;
    end else hc++;
    @(negedge clock);
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(hc == h && vc == v) && n < 200000) begin
      tick();
      n++;
    end
    if (n >= 200000) check("goto_bound", n, 0);
  endtask

  // Overrides line and frame counters across one edge (never at hc=447).
  task automatic jump(input int v, input int f);
    force dut.u_cnt.vCount = 9'(v);
    force dut.u_cnt.frameCount = 5'(f);
    tick();
    release dut.u_cnt.vCount;
    release dut.u_cnt.frameCount;
    vc = v;
    fc = f;
  endtask

  initial begin
    for (int k = 0; k < 8192; k++) mem[k] = 8'h00;
    mem[13'h0000] = 8'h80;  // cell 0: leftmost pixel ink
    mem[13'h1800] = 8'h47;  // ink 7, paper 0, bright
    mem[13'h0001] = 8'hFF;  // cell 1: all ink
    mem[13'h1801] = 8'h87;  // ink 7, paper 0, flash

    reset  = 1'b1;
    border = 3'd2;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    hc = 0; vc = 0; fc = 0;

    goto(8, 0);
    check("pre_reset_pix", obs, 4'hF);

    // Mid-frame reset held for three clocks.
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      @(negedge clock);
      check("reset_outputs", {vmmAddr, hsync, vsync, irq, obs}, 0);
    end
    reset = 1'b0;
    hc = 0; vc = 0; fc = 0;

    check("addr_h0", vmmAddr, 13'h0000);
    goto(1, 0);   check("addr_attr_c0", vmmAddr, 13'h1800);
    goto(2, 0);   check("addr_idle_p2", vmmAddr, 13'h0000);
    goto(7, 0);   check("border_h7", obs, 4'h8);
    goto(8, 0);   check("pix_ink_bright", obs, 4'hF);
    goto(9, 0);   check("pix_paper_h9", obs, 4'h1);
    goto(15, 0);  check("pix_paper_h15", obs, 4'h1);
    goto(16, 0);  check("flash_off_h16", obs, 4'hE);
    goto(23, 0);  check("flash_off_h23", obs, 4'hE);
    goto(24, 0);  check("pix_zero_cell", obs, 4'h0);
    goto(264, 0); check("border_h264", obs, 4'h8);
    goto(343, 0); check("hsync_h343", hsync, 1'b0);
    goto(344, 0); check("hsync_h344", hsync, 1'b1);
    goto(375, 0); check("hsync_h375", hsync, 1'b1);
    goto(376, 0); check("hsync_h376", hsync, 1'b0);

    goto(300, 0);
    border = 3'd7;
    goto(319, 0); check("border7_h319", obs, 4'hE);
`ifdef VIDEO_BLANK_EN
    check("blank_h319", blank, 1'b0);
    goto(320, 0); check("blank_h320", blank, 1'b1);
    check("blank_rgbi_h320", obs, 4'h0);
    goto(416, 0); check("blank_h416", blank, 1'b0);
    check("rgbi_h416", obs, 4'hE);
`else
    goto(320, 0); check("border7_h320", obs, 4'hE);
`endif

    goto(420, 0);
    jump(64, fc);
    goto(8, 65);   check("addr_bmp_y65_c1", vmmAddr, 13'h0901);
    goto(9, 65);   check("addr_attr_y65_c1", vmmAddr, 13'h1901);
    goto(10, 65);  check("addr_idle_y65", vmmAddr, 13'h0000);
    goto(256, 65); check("addr_out_window", vmmAddr, 13'h0000);

    goto(260, 65);
    jump(239, fc);
    goto(100, 239); check("border7_v239", obs, 4'hE);
`ifdef VIDEO_BLANK_EN
    check("blank_v239", blank, 1'b0);
    goto(100, 240); check("blank_v240", blank, 1'b1);
    check("blank_rgbi_v240", obs, 4'h0);
`else
    goto(100, 240); check("border7_v240", obs, 4'hE);
`endif

    // Sync and interrupt over lines 246..253.
    goto(0, 246);
    vs_cnt = 0; irq_cnt = 0; irq_h = -1; irq_v = -1;
    for (int ln = 0; ln < 8; ln++) begin
      hs = 0;
      for (int h = 0; h < 448; h++) begin
        if (hsync) hs++;
        if (vsync) vs_cnt++;
        if (irq) begin
          if (irq_cnt == 0) begin
            irq_h = hc;
            irq_v = vc;
          end
          irq_cnt++;
        end
        tick();
      end
      check($sformatf("hsync_len_v%0d", 246 + ln), hs, 32);
    end
    check("vsync_clocks", vs_cnt, 4 * 448);
    check("irq_clocks", irq_cnt, 64);
    check("irq_start_v", irq_v, 248);
    check("irq_start_h", irq_h, 0);

    // Flash phase follows frameCount bit 4.
    goto(10, 254);
    jump(311, fc);
    goto(16, 0);  check("flash_f1", obs, 4'hE);
    goto(100, 0);
    jump(311, 15);
    goto(8, 0);   check("noflash_f16", obs, 4'hF);
    goto(16, 0);  check("flash_f16", obs, 4'h0);
    goto(100, 0);
    jump(311, 31);
    goto(16, 0);  check("flash_f32_wrap", obs, 4'hE);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
